// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter.
// Contents:
//   WORD_BYTES / CNT_W : bytes per word access and the byte counter width
//   arb_state_t        : arbiter FSM states (IDLE, ACC, DONE)
//   owner_t            : which requester owns the current access
//   pick_winner        : two-way round-robin grant decision
package mem_port_arbiter_pkg;

   localparam int WORD_BYTES = 4;
   localparam int CNT_W      = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_t;

   // On a tie the requester that was not served last time wins, so neither
   // side can be starved while both hold their requests.
   function automatic owner_t pick_winner(input logic if_req,
                                          input logic d_req,
                                          input owner_t last_owner);
      if (if_req && d_req) begin
         return (last_owner == OWN_IF) ? OWN_D : OWN_IF;
      end else if (d_req) begin
         return OWN_D;
      end else begin
         return OWN_IF;
      end
   endfunction

endpackage

// File: rtl/mem_port_arbiter_word_serializer.sv
// Splits one 32-bit word access into four little-endian byte cycles.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   start              : latch base/we/wdata and restart the byte counter
//   advance            : one byte cycle completes at this edge
//   we, base, wdata    : access parameters captured on start
//   mem_rdata          : byte read from the array at mem_adr
//   mem_adr, mem_wdata : byte address (wraps at ADDR_W) and byte to write
//   write              : captured write flag of the current access
//   last_byte          : the current byte cycle is the final one
//   word               : read word including the byte on the bus right now
module mem_port_arbiter_word_serializer
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    advance,
   input  logic                    we,
   input  logic [ADDR_W-1:0]       base,
   input  logic [WORD_BYTES*8-1:0] wdata,
   input  logic [7:0]              mem_rdata,
   output logic [ADDR_W-1:0]       mem_adr,
   output logic [7:0]              mem_wdata,
   output logic                    write,
   output logic                    last_byte,
   output logic [WORD_BYTES*8-1:0] word
);

   logic [CNT_W-1:0]        byte_cnt;
   logic [ADDR_W-1:0]       base_q;
   logic [WORD_BYTES*8-1:0] wdata_q;
   logic                    write_q;
   logic [WORD_BYTES*8-1:0] capture_q;

   // Access parameters are frozen at start so the requester may change its
   // inputs freely once granted; read bytes land in lane byte_cnt.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_cnt  <= '0;
         base_q    <= '0;
         wdata_q   <= '0;
         write_q   <= 1'b0;
         capture_q <= '0;
      end else if (start) begin
         byte_cnt  <= '0;
         base_q    <= base;
         wdata_q   <= wdata;
         write_q   <= we;
         capture_q <= '0;
      end else if (advance) begin
         byte_cnt <= byte_cnt + 1'b1;
         if (!write_q) begin
            capture_q[8*byte_cnt +: 8] <= mem_rdata;
         end
      end
   end

   // The adder is ADDR_W wide so the sequence wraps past the top of memory.
   assign mem_adr   = base_q + ADDR_W'(byte_cnt);
   assign mem_wdata = wdata_q[8*byte_cnt +: 8];
   assign write     = write_q;
   assign last_byte = (byte_cnt == CNT_W'(WORD_BYTES - 1));

   // Merging the live byte lets the owner's output register take the full
   // word on the same edge that ends the last byte cycle.
   always_comb begin
      word = capture_q;
      word[8*byte_cnt +: 8] = mem_rdata;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a byte-wide 64 KiB memory between instruction fetch (read
// only) and data load/store; each word access is four byte cycles.
// Ports:
//   clk, rst                        : clock, asynchronous active-high reset
//   if_req, if_adr                  : fetch request (level) and byte address
//   if_done, if_rdata               : fetch completion pulse and word
//   d_req, d_we, d_adr, d_wdata     : data request, store flag, address, data
//   d_done, d_rdata                 : data completion pulse and load word
//   mem_adr, mem_wdata, mem_we      : byte interface to the array
//   mem_rdata                       : asynchronous read byte from the array
//   busy                            : an access is in progress
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [31:0]       if_adr,
   output logic              if_done,
   output logic [31:0]       if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [31:0]       d_adr,
   input  logic [31:0]       d_wdata,
   output logic              d_done,
   output logic [31:0]       d_rdata,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   input  logic [7:0]        mem_rdata,
   output logic              busy
);

   arb_state_t        state_q;
   arb_state_t        state_d;
   owner_t            grant;
   owner_t            owner_q;
   owner_t            last_owner_q;
   logic              start;
   logic              advance;
   logic [ADDR_W-1:0] grant_adr;
   logic              grant_we;
   logic              ser_write;
   logic              last_byte;
   logic [31:0]       word;
   logic              unused_adr_hi;

   // Address bits above the array size are ignored.
   assign unused_adr_hi = ^{if_adr[31:ADDR_W], d_adr[31:ADDR_W]};

   // Grant candidate and its address/write flag, used only in IDLE.
   always_comb begin
      grant     = pick_winner(if_req, d_req, last_owner_q);
      grant_adr = (grant == OWN_D) ? d_adr[ADDR_W-1:0] : if_adr[ADDR_W-1:0];
      grant_we  = (grant == OWN_D) && d_we;
   end

   mem_port_arbiter_word_serializer #(
      .ADDR_W (ADDR_W)
   ) u_serializer (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .advance   (advance),
      .we        (grant_we),
      .base      (grant_adr),
      .wdata     (d_wdata),
      .mem_rdata (mem_rdata),
      .mem_adr   (mem_adr),
      .mem_wdata (mem_wdata),
      .write     (ser_write),
      .last_byte (last_byte),
      .word      (word)
   );

   // State register plus the owner bookkeeping for round robin.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         owner_q      <= OWN_IF;
         last_owner_q <= OWN_D;
      end else begin
         state_q <= state_d;
         if (start) begin
            owner_q <= grant;
         end
         if (state_q == ST_DONE) begin
            last_owner_q <= owner_q;
         end
      end
   end

   // Next-state logic; requests are only looked at while idle.
   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      advance = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (if_req || d_req) begin
               start   = 1'b1;
               state_d = ST_ACC;
            end
         end
         ST_ACC: begin
            advance = 1'b1;
            if (last_byte) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy   = (state_q != ST_IDLE);
   assign mem_we = (state_q == ST_ACC) && ser_write;

   // Done pulses and result words are registered on the edge leaving the
   // last byte cycle, so they line up with the DONE state. Stores report 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_done  <= 1'b0;
         d_done   <= 1'b0;
         if_rdata <= '0;
         d_rdata  <= '0;
      end else begin
         if_done <= 1'b0;
         d_done  <= 1'b0;
         if ((state_q == ST_ACC) && last_byte) begin
            if (owner_q == OWN_IF) begin
               if_done  <= 1'b1;
               if_rdata <= word;
            end else begin
               d_done  <= 1'b1;
               d_rdata <= ser_write ? 32'h0 : word;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a transaction-level model with a
// golden memory image, directed cases with literal expectations, then
// randomized requests.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_adr = '0;
   logic        if_done;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_adr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_done;
   logic [31:0] d_rdata;
   logic [15:0] mem_adr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic [7:0]  mem_rdata;
   logic        busy;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_adr    (if_adr),
      .if_done   (if_done),
      .if_rdata  (if_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_adr     (d_adr),
      .d_wdata   (d_wdata),
      .d_done    (d_done),
      .d_rdata   (d_rdata),
      .mem_adr   (mem_adr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   // Physical array driven by the DUT, and the golden image kept by the model.
   logic [7:0] phys_mem [0:65535];
   logic [7:0] ref_mem  [0:65535];

   assign mem_rdata = phys_mem[mem_adr];

   always @(posedge clk) begin
      if (mem_we) phys_mem[mem_adr] <= mem_wdata;
   end

   int total = 0;
   int bad   = 0;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: m_off counts cycles since grant (0 = nothing
   // running, 1..4 = byte k-1 on the bus, 5 = completion cycle).
   int          m_off = 0;
   bit          m_own = 1'b0;
   bit          m_last = 1'b1;
   bit          m_we = 1'b0;
   logic [15:0] m_base = '0;
   logic [31:0] m_wdata = '0;
   logic [31:0] exp_if_rdata = '0;
   logic [31:0] exp_d_rdata = '0;
   bit          exp_if_done = 1'b0;
   bit          exp_d_done = 1'b0;

   always @(posedge clk or posedge rst) begin
      logic [31:0] w;
      if (rst) begin
         m_off = 0;
         m_last = 1'b1;
         exp_if_done = 1'b0;
         exp_d_done = 1'b0;
         exp_if_rdata = '0;
         exp_d_rdata = '0;
      end else begin
         exp_if_done = 1'b0;
         exp_d_done = 1'b0;
         if (m_off == 0) begin
            if (if_req || d_req) begin
               m_own = (if_req && d_req) ? ~m_last : d_req;
               m_base = m_own ? d_adr[15:0] : if_adr[15:0];
               m_we = m_own && d_we;
               m_wdata = d_wdata;
               m_off = 1;
            end
         end else if (m_off <= 4) begin
            if (m_we) ref_mem[m_base + 16'(m_off - 1)] = 8'(m_wdata >> (8 * (m_off - 1)));
            if (m_off == 4) begin
               for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_mem[m_base + 16'(k)];
               if (m_own) begin
                  exp_d_done = 1'b1;
                  exp_d_rdata = m_we ? 32'h0 : w;
               end else begin
                  exp_if_done = 1'b1;
                  exp_if_rdata = w;
               end
            end
            m_off++;
         end else begin
            m_last = m_own;
            m_off = 0;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check_output("busy", {31'd0, busy}, {31'd0, m_off != 0});
      check_output("mem_we", {31'd0, mem_we}, {31'd0, (m_off >= 1 && m_off <= 4 && m_we)});
      if (m_off >= 1 && m_off <= 4) begin
         check_output("mem_adr", {16'd0, mem_adr}, {16'd0, m_base + 16'(m_off - 1)});
         if (m_we) check_output("mem_wdata", {24'd0, mem_wdata}, {24'd0, 8'(m_wdata >> (8 * (m_off - 1)))});
      end
      check_output("if_done", {31'd0, if_done}, {31'd0, exp_if_done});
      check_output("d_done", {31'd0, d_done}, {31'd0, exp_d_done});
      check_output("if_rdata", if_rdata, exp_if_rdata);
      check_output("d_rdata", d_rdata, exp_d_rdata);
   end

   task automatic poke(input logic [15:0] a, input logic [7:0] v);
      phys_mem[a] = v;
      ref_mem[a] = v;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      #2 rst = 1'b0;
   endtask

   // Raises one request, holds it until its done pulse, then drops it.
   task automatic do_access(input bit is_d, input bit we, input logic [31:0] adr,
                            input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
      lat = 0;
      rdata = '0;
      if (is_d) begin
         d_req = 1'b1; d_we = we; d_adr = adr; d_wdata = wdata;
      end else begin
         if_req = 1'b1; if_adr = adr;
      end
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (is_d ? d_done : if_done) begin
            lat = i;
            rdata = is_d ? d_rdata : if_rdata;
            break;
         end
      end
      if (is_d) d_req = 1'b0; else if_req = 1'b0;
      if (lat == 0) check_output("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog got=running want=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] rd;
      int          lat;
      logic [3:0]  order;
      int          n;
      int          pulses;
      bit          prev_done;
      int          mism;
      bit          if_hold, d_hold;
      logic [31:0] r;
      logic [15:0] low;

      for (int a = 0; a < 65536; a++) begin
         phys_mem[a] = 8'h00;
         ref_mem[a] = 8'h00;
      end
      poke(16'h0000, 8'hE8); poke(16'h0001, 8'h03);
      poke(16'h0002, 8'h03); poke(16'h0003, 8'h8C);
      poke(16'hFFFE, 8'h11); poke(16'hFFFF, 8'h22);

      @(negedge clk);
      check_output("rst_busy", {31'd0, busy}, 32'd0);
      check_output("rst_mem_adr", {16'd0, mem_adr}, 32'd0);
      check_output("rst_rdata", if_rdata | d_rdata, 32'd0);
      #2 rst = 1'b0;

      // Fetch from address 0: done in the fifth cycle with the assembled word.
      do_access(1'b0, 1'b0, 32'h0, 32'h0, rd, lat);
      check_output("fetch_word", rd, 32'h8C0303E8);
      check_output("fetch_latency", lat, 32'd5);

      // Store then load back at 2000.
      do_access(1'b1, 1'b1, 32'd2000, 32'h00000001, rd, lat);
      check_output("store_rdata", rd, 32'h0);
      do_access(1'b1, 1'b0, 32'd2000, 32'h0, rd, lat);
      check_output("load_back", rd, 32'h1);
      check_output("store_bytes", {phys_mem[2003], phys_mem[2002], phys_mem[2001], phys_mem[2000]}, 32'h00000001);

      // Both requesting out of reset: alternate IF, D, IF, D.
      apply_reset();
      if_req = 1'b1; if_adr = 32'h0;
      d_req = 1'b1; d_we = 1'b0; d_adr = 32'd2000;
      n = 0; order = '0;
      for (int i = 0; i < 40 && n < 4; i++) begin
         @(negedge clk);
         if (if_done) begin order[n] = 1'b0; n++; end
         else if (d_done) begin order[n] = 1'b1; n++; end
      end
      if_req = 1'b0; d_req = 1'b0;
      check_output("tie_count", n, 32'd4);
      check_output("tie_order", {28'd0, order}, 32'b1010);

      // Load across the top of memory wraps to 0000.
      repeat (2) @(negedge clk);
      do_access(1'b1, 1'b0, 32'h1234FFFE, 32'h0, rd, lat);
      check_output("wrap_load", rd, 32'h03E82211);

      // Reset during the third byte cycle of a store.
      repeat (2) @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_adr = 32'h3000; d_wdata = 32'hAABBCCDD;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_output("rst_mid_we", {31'd0, mem_we}, 32'd0);
      check_output("rst_mid_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      #2 rst = 1'b0; d_req = 1'b0; d_we = 1'b0;
      repeat (3) @(negedge clk);
      check_output("rst_mid_bytes", {phys_mem[16'h3003], phys_mem[16'h3002], phys_mem[16'h3001], phys_mem[16'h3000]}, 32'h0000CCDD);

      // Fetch whose request drops right after grant still completes once.
      if_req = 1'b1; if_adr = 32'h4;
      @(negedge clk);
      if_req = 1'b0;
      pulses = 0; prev_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (prev_done) check_output("busy_after_done", {31'd0, busy}, 32'd0);
         prev_done = if_done;
         if (if_done) pulses++;
      end
      check_output("drop_pulses", pulses, 32'd1);

      // Randomized traffic; inputs wander after grant and requests may drop.
      if_hold = 1'b0; d_hold = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         if (if_done && ($urandom_range(0, 1) == 0)) if_hold = 1'b0;
         if (d_done && ($urandom_range(0, 1) == 0)) d_hold = 1'b0;
         if (!if_hold && ($urandom_range(0, 3) == 0)) if_hold = 1'b1;
         if (!d_hold && ($urandom_range(0, 3) == 0)) d_hold = 1'b1;
         if ($urandom_range(0, 24) == 0) if_hold = 1'b0;
         if ($urandom_range(0, 24) == 0) d_hold = 1'b0;
         r = $urandom;
         low = ($urandom_range(0, 5) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3)) : 16'($urandom_range(0, 47));
         if_adr = {r[31:16], low};
         r = $urandom;
         low = ($urandom_range(0, 5) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3)) : 16'($urandom_range(0, 47));
         d_adr = {r[31:16], low};
         d_wdata = $urandom;
         d_we = ($urandom_range(0, 1) == 1);
         if_req = if_hold;
         d_req = d_hold;
      end
      if_req = 1'b0; d_req = 1'b0;
      repeat (10) @(negedge clk);

      mism = 0;
      for (int a = 0; a < 65536; a++) begin
         if (phys_mem[a] !== ref_mem[a]) mism++;
      end
      check_output("mem_image", mism, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
